// File: rtl/cpu_types_pkg.sv
// Shared CPU-side type definitions: RAM status encoding and arbiter FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2,
        FAULT  = 2'd3
    } arbstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// Two-requester (instruction/data) arbiter for a single RAM port with data priority,
// one-shot instruction fairness after a data transfer, grant timeout and sticky fault.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    arbstate_t     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          ifirst_q, ifirst_d;
    logic          dreq;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            count_q  <= '0;
            ifirst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ifirst_q <= ifirst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ifirst_d = ifirst_q;
        dreq     = dREN | dWEN;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = dreq;
        iload    = '0;
        dload    = '0;

        unique case (state_q)
            IDLE: begin
                count_d = '0;
                // A pending fairness token hands the next slot to the instruction side.
                if (dreq && !(ifirst_q && iREN)) begin
                    state_d  = DGRANT;
                    ifirst_d = 1'b0;
                end else if (iREN) begin
                    state_d  = IGRANT;
                    ifirst_d = 1'b0;
                end
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d  = IDLE;
                    ifirst_d = iREN;
                    if (!RST) begin
                        dwait = 1'b0;
                        dload = ramload;
                    end
                end else if (ramstate == ERROR || count_q == LAST) begin
                    state_d = FAULT;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d = IDLE;
                    if (!RST) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end else if (ramstate == ERROR || count_q == LAST) begin
                    state_d = FAULT;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            FAULT: begin
                state_d = FAULT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign err = (state_q == FAULT);

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised and directed checks of memory_arbiter against a transaction-level model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned TO = 64;
    localparam int OWN_NONE = 0;
    localparam int OWN_D    = 1;
    localparam int OWN_I    = 2;
    localparam int OWN_DEAD = 3;

    logic        CLK = 1'b0;
    logic        RST, iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    ramstate_t   ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the RAM, how long it has waited, and the owed instruction slot.
    int owner  = OWN_NONE;
    int waited = 0;
    bit i_owed = 0;

    // Outputs observed in the most recent step, for directed checks.
    logic        o_iwait, o_dwait, o_ramREN, o_ramWEN, o_err;
    logic [31:0] o_iload, o_dload, o_ramaddr, o_ramstore;

    memory_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs();
        bit dreq, d_done, i_done;
        logic [31:0] e_addr, e_store;
        bit e_ren, e_wen;
        dreq   = dREN | dWEN;
        d_done = (owner == OWN_D) && dreq && (ramstate == ACCESS) && !RST;
        i_done = (owner == OWN_I) && iREN && (ramstate == ACCESS) && !RST;
        e_addr = 0; e_store = 0; e_ren = 0; e_wen = 0;
        if (owner == OWN_D) begin
            e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
        end else if (owner == OWN_I) begin
            e_addr = iaddr; e_ren = iREN;
        end
        check_eq("iwait", {31'b0, iwait}, {31'b0, iREN && !i_done});
        check_eq("dwait", {31'b0, dwait}, {31'b0, dreq && !d_done});
        check_eq("iload", iload, i_done ? ramload : 32'h0);
        check_eq("dload", dload, d_done ? ramload : 32'h0);
        check_eq("ramREN", {31'b0, ramREN}, {31'b0, e_ren});
        check_eq("ramWEN", {31'b0, ramWEN}, {31'b0, e_wen});
        check_eq("ramaddr", ramaddr, e_addr);
        check_eq("ramstore", ramstore, e_store);
        check_eq("err", {31'b0, err}, {31'b0, owner == OWN_DEAD});
        o_iwait = iwait; o_dwait = dwait; o_ramREN = ramREN; o_ramWEN = ramWEN;
        o_err = err; o_iload = iload; o_dload = dload; o_ramaddr = ramaddr;
        o_ramstore = ramstore;
    endtask

    task automatic model_advance();
        bit dreq, still;
        dreq = dREN | dWEN;
        if (RST) begin
            owner = OWN_NONE; waited = 0; i_owed = 0;
            return;
        end
        if (owner == OWN_NONE) begin
            waited = 0;
            if (iREN && (i_owed || !dreq)) begin
                owner = OWN_I; i_owed = 0;
            end else if (dreq) begin
                owner = OWN_D; i_owed = 0;
            end
        end else if (owner != OWN_DEAD) begin
            still = (owner == OWN_D) ? dreq : iREN;
            if (!still) begin
                owner = OWN_NONE;
            end else if (ramstate == ACCESS) begin
                if (owner == OWN_D) i_owed = iREN;
                owner = OWN_NONE;
            end else begin
                waited++;
                if (ramstate == ERROR || waited >= TO) owner = OWN_DEAD;
            end
        end
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic step(input logic r, input logic ir, input logic dr, input logic dw,
                        input ramstate_t rs);
        RST = r; iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
        #4;
        compare_outputs();
        @(posedge CLK);
        model_advance();
        #1;
    endtask

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        @(posedge CLK); #1;
        model_advance();

        // Reset state
        step(1, 0, 0, 0, FREE);
        step(0, 0, 0, 0, FREE);
        check_eq("rst_err", {31'b0, o_err}, 32'h0);
        check_eq("rst_strobes", {30'b0, o_ramREN, o_ramWEN}, 32'h0);

        // Instruction fetch: BUSY, BUSY, ACCESS
        iaddr = 32'h40; ramload = 32'h8C010004;
        step(0, 1, 0, 0, BUSY);
        step(0, 1, 0, 0, BUSY);
        check_eq("ifetch_addr", o_ramaddr, 32'h40);
        check_eq("ifetch_wait1", {31'b0, o_iwait}, 32'h1);
        step(0, 1, 0, 0, BUSY);
        step(0, 1, 0, 0, ACCESS);
        check_eq("ifetch_done", {31'b0, o_iwait}, 32'h0);
        check_eq("ifetch_load", o_iload, 32'h8C010004);
        check_eq("ifetch_wen", {31'b0, o_ramWEN}, 32'h0);
        step(0, 0, 0, 0, FREE);

        // Simultaneous write and fetch: data first, then instruction after one idle cycle
        daddr = 32'h100; dstore = 32'hDEADBEEF; iaddr = 32'h44;
        step(0, 1, 0, 1, BUSY);
        step(0, 1, 0, 1, ACCESS);
        check_eq("dfirst_wen", {31'b0, o_ramWEN}, 32'h1);
        check_eq("dfirst_store", o_ramstore, 32'hDEADBEEF);
        check_eq("dfirst_addr", o_ramaddr, 32'h100);
        step(0, 1, 0, 1, BUSY);
        check_eq("gap_idle", {30'b0, o_ramREN, o_ramWEN}, 32'h0);
        step(0, 1, 0, 0, ACCESS);
        check_eq("then_i_addr", o_ramaddr, 32'h44);
        check_eq("then_i_ren", {31'b0, o_ramREN}, 32'h1);
        step(0, 0, 0, 0, FREE);

        // Continuous contention: grants alternate D, I, D, I
        daddr = 32'h200; iaddr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 0, ACCESS);
            step(0, 1, 1, 0, ACCESS);
            check_eq("alt_addr", o_ramaddr, (k % 2 == 0) ? 32'h200 : 32'h300);
        end
        step(0, 0, 0, 0, FREE);
        step(1, 0, 0, 0, FREE);

        // Data request withdrawn before ACCESS
        step(0, 0, 1, 0, BUSY);
        step(0, 0, 1, 0, BUSY);
        check_eq("abort_granted", {31'b0, o_ramREN}, 32'h1);
        step(0, 0, 0, 0, BUSY);
        check_eq("abort_dwait", {31'b0, o_dwait}, 32'h0);
        step(0, 0, 0, 0, ACCESS);
        check_eq("abort_nodone", o_dload, 32'h0);
        check_eq("abort_idle", {31'b0, o_ramREN}, 32'h0);

        // Timeout: TO waiting cycles fault, one fewer does not
        step(0, 0, 1, 0, BUSY);
        for (int k = 0; k < TO - 1; k++) step(0, 0, 1, 0, BUSY);
        check_eq("to_before", {31'b0, o_err}, 32'h0);
        step(0, 0, 1, 0, BUSY);
        step(0, 1, 1, 0, ACCESS);
        check_eq("to_err", {31'b0, o_err}, 32'h1);
        check_eq("to_nostrobe", {31'b0, o_ramREN}, 32'h0);
        check_eq("to_dwait", {31'b0, o_dwait}, 32'h1);
        check_eq("to_iwait", {31'b0, o_iwait}, 32'h1);
        step(1, 0, 0, 0, FREE);
        step(0, 0, 0, 0, FREE);
        check_eq("to_cleared", {31'b0, o_err}, 32'h0);

        // Reset during an instruction grant
        iaddr = 32'h80;
        step(0, 1, 0, 0, BUSY);
        step(0, 1, 0, 0, BUSY);
        check_eq("rg_granted", {31'b0, o_ramREN}, 32'h1);
        step(1, 1, 0, 0, ACCESS);
        check_eq("rg_nodone", {31'b0, o_iwait}, 32'h1);
        step(0, 1, 0, 0, ACCESS);
        check_eq("rg_dropped", {31'b0, o_ramREN}, 32'h0);
        check_eq("rg_iwait", {31'b0, o_iwait}, 32'h1);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            ramstate_t rs;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(0, 99);
            rs = (r < 40) ? ACCESS : (r < 70) ? BUSY : (r < 98) ? FREE : ERROR;
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 25,
                 rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
